// File: rtl/ff_reduce.sv
// ---------------------------------------------------------------------------
// ff_reduce -- limb-serial reduction of a 510-bit value modulo p = 2^255 - P_C
//
// The reducer sits in front of the field adder and turns a raw 255x255-bit
// product into a fully reduced field element. It has one 64-bit limb adder,
// which is shared by three 4-limb passes:
//   FOLD1 : t = x[254:0] + P_C * x[509:255]      (t < 2^260)
//   FOLD2 : t = t[254:0] + P_C * t[261:255]      (t < 2^256 and t < 2p)
//   SUB   : d = t - p ; out = borrow ? t : d     (0 <= out < p)
// A result is ready 13 cycles after start is accepted.
//
// Parameters
//   P_C    : modulus constant, p = 2^255 - P_C, legal range 1..31
//
// Ports
//   clk    : clock, rising edge
//   rst    : asynchronous reset, active high; clears every register
//   start  : reduction request, sampled only in IDLE
//   x_i    : 510-bit unreduced operand, captured on the accepting edge
//   out    : registered, fully reduced result; holds until next completion
//   done   : result-valid strobe
//   busy   : high from the cycle after acceptance through the done cycle
//
// Build option
//   FF_REDUCE_DONE_HOLD_EN : when defined, done stays high after completion
//                            until the edge that accepts the next start
// ---------------------------------------------------------------------------
module ff_reduce #(
  parameter int P_C = 19
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [509:0] x_i,
  output logic [254:0] out,
  output logic         done,
  output logic         busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FOLD1 = 3'd1,
    FOLD2 = 3'd2,
    SUB   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     lim_q;
  logic [5:0]     c_q;       // limb carry in the folds; 1 = "no borrow" in SUB
  logic [509:0]   x_q;
  logic [261:0]   t_q;
  logic [191:0]   d_q;       // low three limbs of t - p
  logic [254:0]   out_q;

  logic [63:0]    op_a;
  logic [63:0]    mul_in;
  logic [68:0]    mul_out;
  logic [68:0]    op_b;
  logic [69:0]    sum;
  logic           last_limb;

  // Limb k of a 255-bit value; the top limb is only 63 bits wide.
  function automatic logic [63:0] limb255(input logic [254:0] v, input logic [1:0] k);
    logic [63:0] r;
    case (k)
      2'd0:    r = v[63:0];
      2'd1:    r = v[127:64];
      2'd2:    r = v[191:128];
      default: r = {1'b0, v[254:192]};
    endcase
    return r;
  endfunction

  // Multiply by the constant P_C using only shifts and adds.
  function automatic logic [68:0] mul_pc(input logic [63:0] a);
    logic [68:0] acc;
    acc = '0;
    for (int i = 0; i < 5; i++) begin
      if (P_C[i]) acc = acc + ({5'b0, a} << i);
    end
    return acc;
  endfunction

  // Ones' complement of limb k of p. p = 2^255 - P_C, so its limbs are
  // 2^64 - P_C, all ones, all ones and 2^63 - 1; t - p is then formed as
  // t + ~p + 1 with the "+1" supplied by the initial no-borrow carry.
  function automatic logic [63:0] p_limb_inv(input logic [1:0] k);
    logic [63:0] r;
    case (k)
      2'd0:    r = 64'(P_C - 1);
      2'd3:    r = 64'h8000_0000_0000_0000;
      default: r = 64'h0;
    endcase
    return r;
  endfunction

  assign last_limb = (lim_q == 2'd3);

  // Operand selection for the single limb adder.
  always_comb begin
    op_a   = '0;
    mul_in = '0;
    op_b   = '0;
    case (state_q)
      FOLD1: begin
        op_a   = limb255(x_q[254:0], lim_q);
        mul_in = limb255(x_q[509:255], lim_q);
      end
      FOLD2: begin
        // The whole fold value enters at limb 0; later limbs only ripple carry.
        op_a   = limb255(t_q[254:0], lim_q);
        mul_in = (lim_q == 2'd0) ? {57'b0, t_q[261:255]} : 64'h0;
      end
      SUB: begin
        op_a = t_q[64*lim_q +: 64];
      end
      default: ;
    endcase
    mul_out = mul_pc(mul_in);
    op_b    = (state_q == SUB) ? {5'b0, p_limb_inv(lim_q)} : mul_out;
    sum     = {6'b0, op_a} + {1'b0, op_b} + {64'b0, c_q};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = FOLD1;
      FOLD1:   if (last_limb) state_d = FOLD2;
      FOLD2:   if (last_limb) state_d = SUB;
      SUB:     if (last_limb) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lim_q   <= '0;
      c_q     <= '0;
      x_q     <= '0;
      t_q     <= '0;
      d_q     <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            x_q   <= x_i;
            c_q   <= '0;
            lim_q <= '0;
          end
        end
        FOLD1, FOLD2: begin
          lim_q <= lim_q + 2'd1;
          if (last_limb) begin
            // Top limb keeps its carry-out as t[261:256] for the next fold.
            t_q[261:192] <= sum;
            c_q          <= (state_q == FOLD1) ? 6'd0 : 6'd1;
          end else begin
            t_q[64*lim_q +: 64] <= sum[63:0];
            c_q                 <= sum[69:64];
          end
        end
        SUB: begin
          lim_q <= lim_q + 2'd1;
          c_q   <= {5'b0, sum[64]};
          case (lim_q)
            2'd0: d_q[63:0]    <= sum[63:0];
            2'd1: d_q[127:64]  <= sum[63:0];
            2'd2: d_q[191:128] <= sum[63:0];
            default: begin
              // Carry out of the top limb set means t >= p: keep the difference.
              out_q <= sum[64] ? {sum[62:0], d_q} : t_q[254:0];
            end
          endcase
        end
        default: ;
      endcase
    end
  end

`ifdef FF_REDUCE_DONE_HOLD_EN
  logic done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      done_q <= 1'b0;
    end else if (state_q == SUB && last_limb) begin
      done_q <= 1'b1;
    end
  end

  assign done = done_q;
`else
  assign done = (state_q == DONE);
`endif

  assign busy = (state_q != IDLE);
  assign out  = out_q;

endmodule

// File: doc/ff_reduce.md
FF_REDUCE -- requirements
Module: ff_reduce

Interface
REQ-001 Parameter P_C, default 19: modulus p = 2^255 - P_C; legal range 1..31.
REQ-002 clk  input  1  clock, rising-edge active.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to reduce x_i; sampled only in IDLE.
REQ-005 x_i  input  510  unreduced value, typically a 255x255-bit product.
REQ-006 out  output  255  x_i mod p, fully reduced (0 <= out < p), registered.
REQ-007 done  output  1  result-valid strobe.
REQ-008 busy  output  1  high from the cycle after start is accepted until the done cycle, inclusive.

Function
REQ-009 Block SHALL be a limb-serial reducer feeding ffa operands: one 64-bit adder/subtractor datapath, 4 limbs per pass, a limb counter of 0..3, and a multiply-by-P_C built from shift-add only.
REQ-010 FSM states SHALL be IDLE, FOLD1, FOLD2, SUB and DONE.
REQ-011 IDLE + start=1: capture x_i into an internal register, clear the carry and limb counter, and go to FOLD1; start=0 stays in IDLE.
REQ-012 FOLD1 (4 cycles): t = x[254:0] + P_C*x[509:255], one 64-bit limb per cycle with a carry of at least 6 bits between limbs; t may be up to 262 bits wide.
REQ-013 FOLD2 (4 cycles): t = t[254:0] + P_C*t[261:255], where the fold value enters limb 0; the result is < 2^256 and < 2p.
REQ-014 SUB (4 cycles): d = t - p limb-serially with a borrow chain; on the last limb, out <= (final borrow) ? t[254:0] : d[254:0].
REQ-015 Latency: done SHALL be high in exactly the 13th cycle after the rising edge that samples start.
REQ-016 done SHALL pulse for that single cycle; the FSM then returns to IDLE.
REQ-017 out SHALL hold its value until the next completion.
REQ-018 start while busy=1 SHALL be ignored and not queued.
REQ-019 start high in the DONE cycle SHALL be ignored; start high in the following IDLE cycle SHALL be accepted.
REQ-020 x_i SHALL be sampled only on the accepting edge; later changes to x_i SHALL NOT affect the result.
REQ-021 Inputs >= p, including x_i = p and x_i = 2^510-1, SHALL produce a fully reduced result.

Reset
REQ-022 rst=1 SHALL force: state IDLE, out=0, done=0, busy=0, all internal registers 0.
REQ-023 Assertion of rst mid-operation SHALL abort the operation; no done SHALL follow, and the first start after release SHALL behave as from power-up.

Configuration
REQ-024 Macro FF_REDUCE_DONE_HOLD_EN defined: done SHALL rise at the time given in REQ-015 and stay high until the edge that accepts the next start (it drops in the next cycle) or until rst.
REQ-025 Macro FF_REDUCE_DONE_HOLD_EN undefined: done SHALL be the single-cycle pulse of REQ-016.
REQ-026 Latency, out and busy SHALL be identical under both settings.

Verification
REQ-027 x_i=0, start 1 cycle -> done on cycle 13, out=0, busy high cycles 1..13.
REQ-028 x_i=p, x_i=p-1, x_i=2^255 -> out=0, p-1 and 19 respectively.
REQ-029 x_i=(p-1)^2 -> out=1; x_i=2^510-1 -> out=360.
REQ-030 Start accepted, new start and changed x_i at cycle 5 -> single done at cycle 13 with the first result, no second done.
REQ-031 rst pulsed at cycle 7 of an operation -> out=0, done never asserted; a restart with x_i=2^255+5 -> out=24.
REQ-032 1000 random 510-bit x_i, run both with and without FF_REDUCE_DONE_HOLD_EN -> out matches a reference model x_i mod p; done width is 1 cycle or held per REQ-024/025.
